// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and the width-generic ALU function.
// alu_compute works on MAX_W-bit words and a runtime-constant width w.
package alu_pkg;

    localparam int OP_W  = 4;
    localparam int MAX_W = 64;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h5;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h6;
    localparam logic [OP_W-1:0] OP_LT   = 4'h7;
    localparam logic [OP_W-1:0] OP_EQ   = 4'h8;
    localparam logic [OP_W-1:0] OP_PASS = 4'h9;
    localparam logic [OP_W-1:0] OP_SRA  = 4'hA;
    localparam logic [OP_W-1:0] OP_SLT  = 4'hB;

    // Bit positions in the alu_compute return word
    localparam int F_CARRY = MAX_W;
    localparam int F_OVF   = MAX_W + 1;
    localparam int F_ILL   = MAX_W + 2;

    // Operands must be zero-extended from w bits; result is masked to w.
    function automatic logic [MAX_W+2:0] alu_compute(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [OP_W-1:0]  op,
        input int               w
    );
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] mask, msb, sa, sb, r;
        logic             sgn_a, sgn_b, sgn_r, big, c, o, ill;
        mask  = {MAX_W{1'b1}} >> (MAX_W - w);
        msb   = MAX_W'(1) << (w - 1);
        sgn_a = |(a & msb);
        sgn_b = |(b & msb);
        sa    = sgn_a ? (a | ~mask) : a;
        sb    = sgn_b ? (b | ~mask) : b;
        big   = (b >= MAX_W'(w));
        sum   = '0;
        r     = '0;
        c     = 1'b0;
        ill   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[MAX_W-1:0] & mask;
                c   = |(sum & ((MAX_W+1)'(1) << w));
            end
            OP_SUB: begin
                r = (a - b) & mask;
                c = (a < b);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = big ? '0 : ((a << b) & mask);
            OP_SHR:  r = big ? '0 : (a >> b);
            OP_SRA:  r = big ? (sgn_a ? mask : '0)
                             : (($signed(sa) >>> b) & mask);
            OP_LT:   r = MAX_W'(a < b);
            OP_EQ:   r = MAX_W'(a == b);
            OP_PASS: r = a;
            OP_SLT:  r = MAX_W'($signed(sa) < $signed(sb));
            default: ill = 1'b1;
        endcase
        sgn_r = |(r & msb);
        o = 1'b0;
        if (op == OP_ADD)
            o = (sgn_a == sgn_b) && (sgn_r != sgn_a);
        else if (op == OP_SUB)
            o = (sgn_a != sgn_b) && (sgn_r != sgn_a);
        return {ill, o, c, r};
    endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/ready register slice; accepts whenever empty or draining.
// Ports: in_valid/in_ready/in_data upstream, out_* downstream.
module alu_pipe_stage
    import alu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          v_q;
    logic [DW-1:0] d_q;

    assign in_ready  = !v_q || out_ready;
    assign out_valid = v_q;
    assign out_data  = d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (in_ready) begin
            v_q <= in_valid;
            if (in_valid)
                d_q <= in_data;
        end
    end

endmodule

// File: rtl/alu_pipelined.sv
// STAGES-deep pipelined ALU with valid/ready on both sides and a tag sideband.
// Ports: in_valid/in_ready/a/b/op/in_tag in; out_valid/out_ready/result/flags/out_tag out.
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Slice word: {tag, illegal, overflow, carry, zero, result}
    localparam int DW = TAG_W + 4 + WIDTH;

    logic [MAX_W+2:0] calc;
    logic [WIDTH-1:0] res;
    logic             unused_calc;

    assign calc = alu_compute(MAX_W'(a), MAX_W'(b), op, WIDTH);
    assign res  = calc[WIDTH-1:0];
    assign unused_calc = ^calc[MAX_W-1:WIDTH];

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [DW-1:0]   dat [STAGES+1];

    assign vld[0] = in_valid;
    assign dat[0] = {in_tag, calc[F_ILL], calc[F_OVF],
                     calc[F_CARRY], (res == '0), res};
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        alu_pipe_stage #(.DW(DW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[i]),
            .in_ready  (rdy[i]),
            .in_data   (dat[i]),
            .out_valid (vld[i+1]),
            .out_ready (rdy[i+1]),
            .out_data  (dat[i+1])
        );
    end

    assign out_valid = vld[STAGES];
    assign {out_tag, illegal, overflow, carry, zero, result} = dat[STAGES];

endmodule

// File: tb/tb_alu_pipelined.sv
// Directed self-checking bench for alu_pipelined (WIDTH=8, STAGES=2).
// Covers ALU ops, backpressure, latency/throughput and mid-stream reset.
module tb_alu_pipelined;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] a, b;
    logic [3:0] op;
    logic [3:0] in_tag;
    logic       out_valid, out_ready;
    logic [7:0] result;
    logic       zero, carry, overflow, illegal;
    logic [3:0] out_tag;

    int errors = 0;
    int checks = 0;

    alu_pipelined #(.WIDTH(8), .STAGES(2), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Single op into an empty pipe; flags checked as {z,c,o,ill}
    task automatic do_op(input string nm, input logic [7:0] ai,
                         input logic [7:0] bi, input logic [3:0] opi,
                         input logic [3:0] ti, input logic [7:0] er,
                         input logic [3:0] ef);
        int n;
        in_valid = 1'b1;
        a = ai;
        b = bi;
        op = opi;
        in_tag = ti;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, n, 1);
        chk({nm, " result"}, 32'(result), 32'(er));
        chk({nm, " flags"}, 32'({zero, carry, overflow, illegal}), 32'(ef));
        chk({nm, " tag"}, 32'(out_tag), 32'(ti));
        tick();
    endtask

    initial begin
        logic [3:0] got_tags[$];
        logic [7:0] snap_res;
        logic [3:0] snap_tag;
        logic       first_seen, saw_full, stale;
        int         stall, nt, ni, no, cyc;
        int         acc_cyc[10];

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        in_tag = '0;
        out_ready = 1'b1;
        #2;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst result", 32'(result), 0);
        chk("rst tag", 32'(out_tag), 0);
        chk("rst flags", 32'({zero, carry, overflow, illegal}), 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("post-rst in_ready", 32'(in_ready), 1);

        // flags = {zero, carry, overflow, illegal}
        do_op("add 7f+01", 8'h7F, 8'h01, OP_ADD, 4'd1, 8'h80, 4'b0010);
        do_op("add ff+01", 8'hFF, 8'h01, OP_ADD, 4'd2, 8'h00, 4'b1100);
        do_op("sub 80-01", 8'h80, 8'h01, OP_SUB, 4'd3, 8'h7F, 4'b0010);
        do_op("sub 05-10", 8'h05, 8'h10, OP_SUB, 4'd4, 8'hF5, 4'b0100);
        do_op("sra 80>>2", 8'h80, 8'h02, OP_SRA, 4'd5, 8'hE0, 4'b0000);
        do_op("sra 80>>9", 8'h80, 8'h09, OP_SRA, 4'd6, 8'hFF, 4'b0000);
        do_op("shl 01<<9", 8'h01, 8'h09, OP_SHL, 4'd7, 8'h00, 4'b1000);
        do_op("shl 81<<1", 8'h81, 8'h01, OP_SHL, 4'd8, 8'h02, 4'b0000);
        do_op("shr f0>>4", 8'hF0, 8'h04, OP_SHR, 4'd9, 8'h0F, 4'b0000);
        do_op("slt ff,01", 8'hFF, 8'h01, OP_SLT, 4'hA, 8'h01, 4'b0000);
        do_op("lt ff,01", 8'hFF, 8'h01, OP_LT, 4'hB, 8'h00, 4'b1000);
        do_op("eq 5a,5a", 8'h5A, 8'h5A, OP_EQ, 4'hC, 8'h01, 4'b0000);
        do_op("xor aa,ff", 8'hAA, 8'hFF, OP_XOR, 4'hD, 8'h55, 4'b0000);
        do_op("and c3,0f", 8'hC3, 8'h0F, OP_AND, 4'hE, 8'h03, 4'b0000);
        do_op("or 50,05", 8'h50, 8'h05, OP_OR, 4'hF, 8'h55, 4'b0000);
        do_op("pass 3c", 8'h3C, 8'hAA, OP_PASS, 4'h0, 8'h3C, 4'b0000);
        do_op("illegal C", 8'h12, 8'h34, 4'hC, 4'h1, 8'h00, 4'b1001);

        // Backpressure: tags 1..5, stall 4 cycles from first out_valid
        first_seen = 1'b0;
        saw_full = 1'b0;
        stall = 0;
        nt = 1;
        snap_res = '0;
        snap_tag = '0;
        cyc = 0;
        while (got_tags.size() < 5 && cyc < 40) begin
            in_valid = (nt <= 5);
            a = 8'(nt);
            b = 8'h10;
            op = OP_ADD;
            in_tag = 4'(nt);
            out_ready = first_seen && (stall >= 4);
            #3;
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                snap_res = result;
                snap_tag = out_tag;
                chk("bp first tag", 32'(out_tag), 1);
            end else if (out_valid && !out_ready) begin
                chk("bp hold result", 32'(result), 32'(snap_res));
                chk("bp hold tag", 32'(out_tag), 32'(snap_tag));
            end
            if (in_valid && !in_ready)
                saw_full = 1'b1;
            if (out_valid && out_ready) begin
                got_tags.push_back(out_tag);
                chk("bp result", 32'(result), 32'(8'h10 + 8'(out_tag)));
            end
            if (out_valid && !out_ready)
                stall++;
            if (in_valid && in_ready)
                nt++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp in_ready dropped", 32'(saw_full), 1);
        chk("bp count", got_tags.size(), 5);
        for (int i = 0; i < got_tags.size(); i++)
            chk("bp order", 32'(got_tags[i]), 32'(i + 1));
        tick();
        tick();
        chk("bp no dup", 32'(out_valid), 0);

        // Throughput/latency: 10 ops back-to-back
        ni = 0;
        no = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (ni < 10);
            a = 8'(ni);
            b = 8'h01;
            op = OP_ADD;
            in_tag = 4'(ni);
            #3;
            if (out_valid) begin
                chk("tp tag", 32'(out_tag), 32'(no));
                chk("tp result", 32'(result), 32'(no + 1));
                if (no < 10)
                    chk("tp latency", c, acc_cyc[no] + 2);
                no++;
            end
            if (in_valid) begin
                chk("tp in_ready", 32'(in_ready), 1);
                if (in_ready) begin
                    acc_cyc[ni] = c;
                    ni++;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        chk("tp count", no, 10);

        // Reset with two ops in flight
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        op = OP_ADD;
        in_tag = 4'h7;
        tick();
        in_tag = 4'h8;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 32'(out_valid), 0);
        chk("mid-rst in_ready", 32'(in_ready), 1);
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid)
                stale = 1'b1;
            tick();
        end
        chk("no stale result", 32'(stale), 0);
        chk("after-rst in_ready", 32'(in_ready), 1);
        do_op("after-rst add", 8'h21, 8'h12, OP_ADD, 4'h3, 8'h33, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
